uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among `N_REQ` byte producers. It sits between the producers and the `UART_TX` instance, clocked by `TX_CLK`. Each cycle the block selects one pending requester, presents its byte on the transmitter's parallel input with a one-cycle valid pulse, and then tracks the transmitter's busy flag until the frame completes. A watchdog recovers the block if the transmitter never starts.

## Interface
Parameters:
- `WIDTH`, 8, data byte width; matches `UART_TX` `WIDTH`.
- `N_REQ`, 4, number of requesters, 2..8.
- `START_TMO`, 15, cycles allowed between the issue pulse and `TX_BUSY` rising.

Ports:
- `TX_CLK`  in  1  single clock for the whole block.
- `RST`  in  1  asynchronous, active-high reset.
- `REQ_V`  in  `N_REQ`  per-requester "byte pending"; held high until acknowledged.
- `REQ_DATA`  in  `N_REQ*WIDTH`  requester i's byte is in bits `[i*WIDTH +: WIDTH]`.
- `REQ_ACK`  out  `N_REQ`  one-hot, one-cycle pulse; the byte has been handed to the transmitter.
- `TX_IN_P`  out  `WIDTH`  byte to the transmitter.
- `TX_IN_V`  out  1  one-cycle load strobe to the transmitter.
- `TX_BUSY`  in  1  transmitter frame in progress; wired to `UART_TX` `TX_OUT_V`.
- `GRANT_ID`  out  `$clog2(N_REQ)`  index of the current or last granted requester.
- `ARB_IDLE`  out  1  high in `IDLE` state.
- `TMO_ERR`  out  1  sticky flag; set on a start timeout, cleared only by `RST`.

## Operation
- The FSM has four states: `IDLE`, `ISSUE`, `WAIT_START`, `WAIT_DONE`.
- **IDLE**
  - If `|REQ_V` is 1, pick the winner: the first set bit scanning upward, with wrap, from `PTR`. Latch its byte into `TX_IN_P` and its index into `GRANT_ID`, then go to `ISSUE`.
  - If `|REQ_V` is 0, stay in `IDLE`.
- **ISSUE** (exactly 1 cycle)
  - `TX_IN_V` = 1 and `REQ_ACK[GRANT_ID]` = 1.
  - `PTR` <= `GRANT_ID` + 1, modulo `N_REQ`.
  - Go to `WAIT_START`. Clear `TMO_CNT`.
- **WAIT_START**
  - When `TX_BUSY` = 1, go to `WAIT_DONE`.
  - Otherwise increment `TMO_CNT`. When `TMO_CNT` = `START_TMO`, set `TMO_ERR` and go to `IDLE`. The byte is dropped and has already been acknowledged.
- **WAIT_DONE**
  - When `TX_BUSY` = 0, go to `IDLE`.
- **Register outputs:** `TX_IN_P`, `GRANT_ID`, `REQ_ACK`, `TX_IN_V` and `TMO_ERR` are registered. `ARB_IDLE` is decoded from the state.
- **Width rules:**
  - `PTR` and `GRANT_ID` are `$clog2(N_REQ)` bits. Wrap is explicit, so it is correct when `N_REQ` is not a power of two.
  - `TMO_CNT` is `$clog2(START_TMO+1)` bits and saturates.
- **Boundary conditions:**
  - **All requesters pending:** strict rotation, so each requester is served once per `N_REQ` frames.
  - **Only requester i pending:** served back-to-back, one frame at a time.
  - **Late `REQ_V`:** a `REQ_V` that rises while the block is not in `IDLE` waits for `IDLE`. It is not lost.
  - **`REQ_V` dropped before ACK:** protocol violation. Arbitration uses only the `REQ_V` value sampled in `IDLE`.
  - **`TX_BUSY` already high in `ISSUE`:** ignored. The block still passes through `WAIT_START`.
  - **Reset mid-frame:** the FSM returns to `IDLE` immediately. The transmitter is reset by the same `RST`.

## Timing
- **Reset values:**
  - State = `IDLE`, `PTR` = 0, `GRANT_ID` = 0.
  - `TX_IN_P` = 0, `TX_IN_V` = 0, `REQ_ACK` = 0, `TMO_ERR` = 0, `ARB_IDLE` = 1.
- **Grant latency:** `REQ_V` sampled high in `IDLE` at edge n gives `TX_IN_V` and `REQ_ACK` high for the cycle following edge n+1.
- **Issue spacing:** at least 3 cycles plus the frame length between successive `TX_IN_V` pulses. The block never issues while `TX_BUSY` = 1.
- **Timeout exit:** `START_TMO` + 1 cycles after `ISSUE` if `TX_BUSY` never rises.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding `arb_state_t` (`IDLE`/`ISSUE`/`WAIT_START`/`WAIT_DONE`);
  - the default `WIDTH` and the `START_BIT`/`STOP_BIT` constants shared with `UART_TX`/`UART_RX`.
- One sub-module, `rr_pick`: a combinational rotating priority encoder. Inputs are `REQ_V` and `PTR`; outputs are the winner index and a `found` flag. It is reusable by a future RX-side dispatcher.
- The top-level UART integration instantiates `uart_tx_arbiter` ahead of `UART_TX`, sharing `TX_CLK` and `RST`.

## Test plan
- **Single request:** reset, `REQ_V`=4'b0010, `REQ_DATA[15:8]`=8'hA5 -> one `TX_IN_V` pulse with `TX_IN_P`=8'hA5, `REQ_ACK`=4'b0010, `GRANT_ID`=1, and after the frame `ARB_IDLE` returns to 1.
- **Full contention:** `REQ_V`=4'b1111 held, re-raised after each ACK -> grant order 0,1,2,3,0,1, with `RX_OUT_P` from the looped-back `UART_RX` matching each byte.
- **Pointer wrap:** `PTR`=3 after a grant to 2, then `REQ_V`=4'b0101 -> requester 0 granted before 2.
- **Start timeout:** `TX_BUSY` tied to 0, one request -> `TMO_ERR`=1 exactly 16 cycles after `ISSUE`, FSM in `IDLE`, and the next request is still served.
- **Reset mid-frame:** assert `RST` during `WAIT_DONE` -> all outputs at their reset values in the same cycle, no ACK lost or duplicated after release.
- **Late arrival:** request 2 raised during requester 0's `WAIT_DONE` -> served immediately after the frame, with no `TX_IN_V` overlap with `TX_BUSY`.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: arbiter state encoding, default byte width,
// frame bit levels and a small index-wrap helper.
package uart_tx_arbiter_pkg;

    localparam int   UART_WIDTH = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } arb_state_t;

    // Wrap an index in [0, 2n) back into [0, n); works for any n, not only powers of two.
    function automatic int rr_wrap(input int i, input int n);
        return (i >= n) ? i - n : i;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter side bundle of the TX arbiter. The arbiter takes the
// master view; producers, transmitter and status readers take the slave view.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int WIDTH = UART_WIDTH,
    parameter int N_REQ = 4
);
    localparam int GW = $clog2(N_REQ);

    logic [N_REQ-1:0]       REQ_V;
    logic [N_REQ*WIDTH-1:0] REQ_DATA;
    logic [N_REQ-1:0]       REQ_ACK;
    logic [WIDTH-1:0]       TX_IN_P;
    logic                   TX_IN_V;
    logic                   TX_BUSY;
    logic [GW-1:0]          GRANT_ID;
    logic                   ARB_IDLE;
    logic                   TMO_ERR;

    modport master (
        input  REQ_V, REQ_DATA, TX_BUSY,
        output REQ_ACK, TX_IN_P, TX_IN_V, GRANT_ID, ARB_IDLE, TMO_ERR
    );

    modport slave (
        output REQ_V, REQ_DATA, TX_BUSY,
        input  REQ_ACK, TX_IN_P, TX_IN_V, GRANT_ID, ARB_IDLE, TMO_ERR
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or above ptr, with wrap.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_v,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    idx,
    output logic             found
);
    logic [PW-1:0] cand;

    // Scan from the farthest offset down so the closest one to ptr wins last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = PW'(rr_wrap(int'(ptr) + k, N_REQ));
            if (req_v[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte producers,
// with a start watchdog in case the transmitter never raises busy.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int WIDTH     = UART_WIDTH,
    parameter int N_REQ     = 4,
    parameter int START_TMO = 15
) (
    input  logic              TX_CLK,
    input  logic              RST,
    uart_tx_arbiter_if.master bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(START_TMO + 1);

    arb_state_t    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;
    logic [CW-1:0] tmo_cnt;
    logic [CW-1:0] tmo_nxt;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req_v (bus.REQ_V),
        .ptr   (ptr),
        .idx   (win),
        .found (found)
    );

    // Saturating watchdog increment.
    always_comb tmo_nxt = (tmo_cnt == CW'(START_TMO)) ? tmo_cnt : tmo_cnt + CW'(1);

    assign bus.ARB_IDLE = (state == IDLE);

    // Arbitration / issue / busy-tracking FSM; strobe and ack default low each cycle.
    always_ff @(posedge TX_CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            ptr          <= '0;
            tmo_cnt      <= '0;
            bus.GRANT_ID <= '0;
            bus.TX_IN_P  <= '0;
            bus.TX_IN_V  <= 1'b0;
            bus.REQ_ACK  <= '0;
            bus.TMO_ERR  <= 1'b0;
        end else begin
            bus.TX_IN_V <= 1'b0;
            bus.REQ_ACK <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.TX_IN_P  <= bus.REQ_DATA[win*WIDTH +: WIDTH];
                        bus.GRANT_ID <= win;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.TX_IN_V <= 1'b1;
                    for (int i = 0; i < N_REQ; i++)
                        bus.REQ_ACK[i] <= (bus.GRANT_ID == PW'(i));
                    ptr     <= (bus.GRANT_ID == PW'(N_REQ - 1)) ? '0 : bus.GRANT_ID + PW'(1);
                    tmo_cnt <= '0;
                    state   <= WAIT_START;
                end
                WAIT_START: begin
                    // Busy already high during ISSUE is only acted on here.
                    if (bus.TX_BUSY) begin
                        state <= WAIT_DONE;
                    end else begin
                        tmo_cnt <= tmo_nxt;
                        if (tmo_nxt == CW'(START_TMO)) begin
                            bus.TMO_ERR <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!bus.TX_BUSY) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of single grants, directed multi-cycle
// corners, then randomized producers and a transmitter model checked against
// a round-robin reference.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 8;
    localparam int TMO = 15;

    logic TX_CLK = 1'b0;
    logic RST    = 1'b1;

    uart_tx_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus ();

    uart_tx_arbiter #(.WIDTH(W), .N_REQ(N), .START_TMO(TMO)) dut (
        .TX_CLK (TX_CLK),
        .RST    (RST),
        .bus    (bus.master)
    );

    always #5 TX_CLK = ~TX_CLK;

    int n_chk  = 0;
    int n_pass = 0;

    // input history per clock edge, used to know what the arbiter sampled
    int               cyc = 0;
    logic [N-1:0]     hv [64];
    logic [N*W-1:0]   hd [64];
    always @(posedge TX_CLK) begin
        hv[cyc % 64] <= bus.REQ_V;
        hd[cyc % 64] <= bus.REQ_DATA;
        cyc          <= cyc + 1;
    end

    int mptr = 0;
    int gq[$];
    bit tx_en = 0, rnd_en = 0, keep = 0, drain = 0;
    int dly = 0, len = 0;
    int nraise = 0, ngrant = 0;

    typedef struct {
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
        int             gid;
        logic [W-1:0]   p;
    } vec_t;
    vec_t tv[8];
    int exp_ord[6] = '{0, 1, 2, 3, 0, 1};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: first pending requester scanning upward from p with wrap.
    function automatic int rr(input logic [N-1:0] v, input int p);
        for (int o = 0; o < N; o++)
            if (v[(p + o) % N]) return (p + o) % N;
        return -1;
    endfunction

    // One clock: observe outputs on the falling edge, then update models/drives.
    task automatic step();
        int a, w;
        @(negedge TX_CLK);
        if (bus.TX_IN_V) begin
            a = (cyc - 2) % 64;
            w = rr(hv[a], mptr);
            gq.push_back(int'(bus.GRANT_ID));
            ngrant++;
            chk("issue_had_req", 64'(w >= 0), 1);
            if (w >= 0) begin
                chk("ref_grant_id", bus.GRANT_ID, w);
                chk("ref_tx_in_p", bus.TX_IN_P, hd[a][w*W +: W]);
                chk("ref_req_ack", bus.REQ_ACK, 64'(1) << w);
                mptr = (w + 1) % N;
            end
            chk("no_issue_while_busy", bus.TX_BUSY, 0);
            if (tx_en) begin
                dly = $urandom_range(0, 2);
                len = $urandom_range(1, 5);
            end
        end else if (bus.REQ_ACK != '0) begin
            chk("ack_without_strobe", bus.REQ_ACK, 0);
        end
        if (tx_en) begin
            if (len > 0) begin
                if (dly > 0) begin dly--; bus.TX_BUSY = 1'b0; end
                else begin bus.TX_BUSY = 1'b1; len--; end
            end else bus.TX_BUSY = 1'b0;
        end
        if (rnd_en) begin
            for (int i = 0; i < N; i++) begin
                if (bus.REQ_ACK[i]) begin
                    if (keep) begin
                        bus.REQ_DATA[i*W +: W] = W'($urandom);
                        nraise++;
                    end else bus.REQ_V[i] = 1'b0;
                end else if (!bus.REQ_V[i] && !drain && $urandom_range(0, 3) == 0) begin
                    bus.REQ_V[i] = 1'b1;
                    bus.REQ_DATA[i*W +: W] = W'($urandom);
                    nraise++;
                end
            end
        end
    endtask

    task automatic wait_pulse(input string nm, output int n);
        n = 0;
        do begin step(); n++; end while (!bus.TX_IN_V && n < 40);
        chk({nm, "_strobe"}, bus.TX_IN_V, 1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!(bus.ARB_IDLE && len == 0 && !bus.TX_BUSY) && n < 80) begin step(); n++; end
        chk({nm, "_idle"}, bus.ARB_IDLE, 1);
    endtask

    // Manually driven frame of n busy cycles, then back to idle.
    task automatic frame(input string nm, input int n);
        bus.TX_BUSY = 1'b1;
        repeat (n) step();
        bus.TX_BUSY = 1'b0;
        wait_idle(nm);
    endtask

    task automatic do_rst(input string nm);
        RST = 1'b1;
        bus.TX_BUSY = 1'b0;
        bus.REQ_V = '0;
        len = 0; dly = 0;
        #1;
        chk({nm, "_tx_in_p"}, bus.TX_IN_P, 0);
        chk({nm, "_tx_in_v"}, bus.TX_IN_V, 0);
        chk({nm, "_req_ack"}, bus.REQ_ACK, 0);
        chk({nm, "_tmo_err"}, bus.TMO_ERR, 0);
        chk({nm, "_arb_idle"}, bus.ARB_IDLE, 1);
        chk({nm, "_grant_id"}, bus.GRANT_ID, 0);
        mptr = 0;
        @(negedge TX_CLK);
        @(negedge TX_CLK);
        RST = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, g;
        tv[0] = '{4'b0010, 32'h1122A533, 1, 8'hA5};
        tv[1] = '{4'b1111, 32'h44556677, 2, 8'h55};
        tv[2] = '{4'b0101, 32'h8899AABB, 0, 8'hBB};
        tv[3] = '{4'b0101, 32'h01234567, 2, 8'h23};
        tv[4] = '{4'b1000, 32'hDE000000, 3, 8'hDE};
        tv[5] = '{4'b1000, 32'hAD000000, 3, 8'hAD};
        tv[6] = '{4'b0110, 32'h00F00F00, 1, 8'h0F};
        tv[7] = '{4'b0011, 32'h00003CC3, 0, 8'hC3};

        bus.REQ_V = '0;
        bus.REQ_DATA = '0;
        bus.TX_BUSY = 1'b0;
        @(negedge TX_CLK);
        do_rst("rst");

        // table: one request set per entry, pointer state carried across entries
        foreach (tv[k]) begin
            wait_idle("tbl");
            bus.REQ_V = tv[k].v;
            bus.REQ_DATA = tv[k].d;
            wait_pulse("tbl", n);
            chk("tbl_latency", n, 2);
            chk("tbl_grant_id", bus.GRANT_ID, tv[k].gid);
            chk("tbl_tx_in_p", bus.TX_IN_P, tv[k].p);
            chk("tbl_req_ack", bus.REQ_ACK, 64'(1) << tv[k].gid);
            chk("tbl_not_idle", bus.ARB_IDLE, 0);
            bus.REQ_V = '0;
            frame("tbl", 3);
            chk("tbl_gid_held", bus.GRANT_ID, tv[k].gid);
        end
        chk("tbl_no_tmo", bus.TMO_ERR, 0);

        // late arrival: requester 2 raised while requester 0 is mid-frame
        bus.REQ_V = 4'b0001;
        bus.REQ_DATA = 32'h0000005A;
        wait_pulse("late0", n);
        chk("late0_gid", bus.GRANT_ID, 0);
        bus.REQ_V = '0;
        bus.TX_BUSY = 1'b1;
        step();
        bus.REQ_V[2] = 1'b1;
        bus.REQ_DATA[23:16] = 8'h7E;
        chk("late_raised_busy", bus.ARB_IDLE, 0);
        step();
        step();
        bus.TX_BUSY = 1'b0;
        wait_pulse("late2", n);
        chk("late2_latency", n, 3);
        chk("late2_gid", bus.GRANT_ID, 2);
        chk("late2_data", bus.TX_IN_P, 8'h7E);
        bus.REQ_V = '0;
        frame("late2", 1);

        // start timeout: transmitter never goes busy
        bus.REQ_V = 4'b0100;
        bus.REQ_DATA = 32'h00990000;
        n = 0;
        do begin step(); n++; end while (bus.ARB_IDLE && n < 10);
        bus.REQ_V = '0;
        n = 0;
        do begin step(); n++; end while (!bus.TMO_ERR && n < 40);
        chk("tmo_cycles_after_issue", n, 16);
        chk("tmo_back_idle", bus.ARB_IDLE, 1);
        bus.REQ_V = 4'b1000;
        bus.REQ_DATA = 32'hC1000000;
        wait_pulse("tmo_next", n);
        chk("tmo_next_gid", bus.GRANT_ID, 3);
        bus.REQ_V = '0;
        frame("tmo_next", 2);
        chk("tmo_sticky", bus.TMO_ERR, 1);

        // reset during WAIT_DONE
        bus.REQ_V = 4'b0010;
        bus.REQ_DATA = 32'h00003300;
        wait_pulse("mid", n);
        bus.REQ_V = '0;
        bus.TX_BUSY = 1'b1;
        step();
        step();
        chk("mid_busy_state", bus.ARB_IDLE, 0);
        g = ngrant;
        do_rst("midrst");
        repeat (4) step();
        chk("mid_no_dup", ngrant, g);
        bus.REQ_V = 4'b0110;
        bus.REQ_DATA = 32'h00445500;
        wait_pulse("mid_after", n);
        chk("mid_after_gid", bus.GRANT_ID, 1);
        bus.REQ_V = '0;
        frame("mid_after", 2);

        // full contention from a fresh reset: strict rotation
        do_rst("crst");
        gq.delete();
        tx_en = 1; rnd_en = 1; keep = 1;
        bus.REQ_V = 4'b1111;
        bus.REQ_DATA = $urandom;
        n = 0;
        while (gq.size() < 6 && n < 300) begin step(); n++; end
        chk("cont_count", gq.size() >= 6, 1);
        for (int i = 0; i < 6 && i < gq.size(); i++) chk("cont_order", gq[i], exp_ord[i]);
        rnd_en = 0; keep = 0;
        bus.REQ_V = '0;
        wait_idle("cont");
        step();

        // random producers with the transmitter model
        nraise = 0; ngrant = 0;
        rnd_en = 1;
        repeat (800) step();
        drain = 1;
        n = 0;
        while (!(bus.REQ_V == '0 && bus.ARB_IDLE && len == 0) && n < 400) begin step(); n++; end
        step();
        chk("rnd_drained", bus.REQ_V, 0);
        chk("rnd_grants_eq_raises", ngrant, nraise);
        chk("rnd_no_tmo", bus.TMO_ERR, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
